// File: rtl/message_arbiter_pkg.sv
// Shared definitions for the message-frame arbiter.
// Contents: index/byte widths, FSM state encodings, default watchdog
// timeout, and a wrapping index-increment helper.
package message_arbiter_pkg;

   localparam int unsigned IDX_W           = 3;
   localparam int unsigned BYTE_W          = 8;
   localparam int unsigned CNT_FRAME_W     = 16;
   localparam int unsigned DEFAULT_TIMEOUT = 1024;

   localparam logic [0:0] STATE_IDLE  = 1'b0;
   localparam logic [0:0] STATE_GRANT = 1'b1;

   // Next source index after idx, wrapping at num.
   function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] idx,
                                                 input int unsigned     num);
      if (32'(idx) + 32'd1 >= num) begin
         return IDX_W'(0);
      end
      return idx + IDX_W'(1);
   endfunction

endpackage

// File: rtl/message_arbiter_rr_select.sv
// Combinational round-robin picker.
// Ports:
//   req   : request vector, one bit per source
//   ptr   : highest-priority index for this pick
//   valid : at least one request is set
//   idx   : first requester at or after ptr, wrapping
module message_arbiter_rr_select
   import message_arbiter_pkg::*;
#(
   parameter int unsigned NUM_SRC = 4
) (
   input  logic [NUM_SRC-1:0] req,
   input  logic [IDX_W-1:0]   ptr,
   output logic               valid,
   output logic [IDX_W-1:0]   idx
);

   localparam int unsigned CAND_W = IDX_W + 1;

   logic [CAND_W-1:0] cand;

   // Walk offsets from farthest to nearest so the nearest requester wins.
   always_comb begin
      valid = 1'b0;
      idx   = '0;
      cand  = '0;
      for (int i = int'(NUM_SRC) - 1; i >= 0; i--) begin
         cand = CAND_W'(ptr) + CAND_W'(i);
         if (cand >= CAND_W'(NUM_SRC)) begin
            cand = cand - CAND_W'(NUM_SRC);
         end
         for (int j = 0; j < int'(NUM_SRC); j++) begin
            if ((CAND_W'(j) == cand) && req[j]) begin
               valid = 1'b1;
               idx   = cand[IDX_W-1:0];
            end
         end
      end
   end

endmodule

// File: rtl/message_arbiter.sv
// Frame-level round-robin arbiter between message-frame sources and the
// host transmit byte stage. One source owns the byte stream for a whole
// frame; a watchdog releases a grant held by a stalled source.
// Ports:
//   clk, reset        : clock, asynchronous active-high reset
//   src_data          : byte per source, source i at [8*i+7:8*i]
//   src_data_valid    : per-source byte valid
//   src_frame_valid   : per-source frame request / in-frame flag
//   src_wait          : per-source stall (0 = byte consumed this cycle)
//   tx_data/tx_valid  : registered byte stream to the transmit stage
//   tx_ready          : transmit stage accepts tx_data
//   grant_id          : current or last granted source
//   frame_abort       : one-cycle pulse on watchdog release
//   frame_count       : completed frames, wrapping
module message_arbiter
   import message_arbiter_pkg::*;
#(
   parameter int unsigned NUM_SRC = 4,
   parameter int unsigned TIMEOUT = DEFAULT_TIMEOUT
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic [BYTE_W*NUM_SRC-1:0] src_data,
   input  logic [NUM_SRC-1:0]        src_data_valid,
   input  logic [NUM_SRC-1:0]        src_frame_valid,
   output logic [NUM_SRC-1:0]        src_wait,
   output logic [BYTE_W-1:0]         tx_data,
   output logic                      tx_valid,
   input  logic                      tx_ready,
   output logic [IDX_W-1:0]          grant_id,
   output logic                      frame_abort,
   output logic [CNT_FRAME_W-1:0]    frame_count
);

   localparam int unsigned CNT_W = $clog2(TIMEOUT) + 1;

   logic [0:0]             state_q, state_d;
   logic [IDX_W-1:0]       rr_q, rr_d;
   logic [IDX_W-1:0]       grant_q, grant_d;
   logic [CNT_W-1:0]       idle_q, idle_d;
   logic [BYTE_W-1:0]      tx_data_q, tx_data_d;
   logic                   tx_valid_q, tx_valid_d;
   logic                   abort_q, abort_d;
   logic [CNT_FRAME_W-1:0] count_q, count_d;

   logic                   pick_valid;
   logic [IDX_W-1:0]       pick_idx;
   logic                   cur_fv, cur_dv, take;
   logic [BYTE_W-1:0]      cur_data;

   message_arbiter_rr_select #(.NUM_SRC(NUM_SRC)) u_rr_select (
      .req   (src_frame_valid),
      .ptr   (rr_q),
      .valid (pick_valid),
      .idx   (pick_idx)
   );

   // Mux out the granted source's handshake and byte.
   always_comb begin
      cur_fv   = 1'b0;
      cur_dv   = 1'b0;
      cur_data = '0;
      for (int i = 0; i < int'(NUM_SRC); i++) begin
         if (IDX_W'(i) == grant_q) begin
            cur_fv   = src_frame_valid[i];
            cur_dv   = src_data_valid[i];
            cur_data = src_data[BYTE_W*i +: BYTE_W];
         end
      end
   end

   // Next-state, handshake and datapath decisions.
   always_comb begin
      state_d    = state_q;
      rr_d       = rr_q;
      grant_d    = grant_q;
      idle_d     = idle_q;
      tx_data_d  = tx_data_q;
      tx_valid_d = tx_valid_q;
      abort_d    = 1'b0;
      count_d    = count_q;
      take       = 1'b0;
      src_wait   = '1;

      case (state_q)
         STATE_IDLE: begin
            idle_d = '0;
            if (pick_valid) begin
               grant_d = pick_idx;
               state_d = STATE_GRANT;
            end
         end
         STATE_GRANT: begin
            take = cur_fv & cur_dv & (~tx_valid_q | tx_ready);
            for (int i = 0; i < int'(NUM_SRC); i++) begin
               if (IDX_W'(i) == grant_q) begin
                  src_wait[i] = ~take;
               end
            end
            if (!cur_fv) begin
               count_d = count_q + CNT_FRAME_W'(1);
               rr_d    = next_idx(grant_q, NUM_SRC);
               state_d = STATE_IDLE;
            end else if (take) begin
               idle_d = '0;
            end else if (idle_q == CNT_W'(TIMEOUT - 1)) begin
               // Stalled source: release without counting the frame.
               abort_d = 1'b1;
               rr_d    = next_idx(grant_q, NUM_SRC);
               state_d = STATE_IDLE;
            end else begin
               idle_d = idle_q + CNT_W'(1);
            end
         end
         default: state_d = STATE_IDLE;
      endcase

      // Output register drains independently of the FSM state.
      if (take) begin
         tx_data_d  = cur_data;
         tx_valid_d = 1'b1;
      end else if (tx_ready) begin
         tx_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= STATE_IDLE;
         rr_q       <= '0;
         grant_q    <= '0;
         idle_q     <= '0;
         tx_data_q  <= '0;
         tx_valid_q <= 1'b0;
         abort_q    <= 1'b0;
         count_q    <= '0;
      end else begin
         state_q    <= state_d;
         rr_q       <= rr_d;
         grant_q    <= grant_d;
         idle_q     <= idle_d;
         tx_data_q  <= tx_data_d;
         tx_valid_q <= tx_valid_d;
         abort_q    <= abort_d;
         count_q    <= count_d;
      end
   end

   assign tx_data     = tx_data_q;
   assign tx_valid    = tx_valid_q;
   assign grant_id    = grant_q;
   assign frame_abort = abort_q;
   assign frame_count = count_q;

endmodule

// File: tb/tb_message_arbiter.sv
// Scoreboard bench for message_arbiter: source frames are loaded into
// per-source tables, a round-robin frame-order model fills the expected
// byte queue, and a monitor pops it on every tx handshake.
module tb_message_arbiter;

   localparam int NSRC = 4;
   localparam int TMO  = 16;

   logic                 clk = 1'b0;
   logic                 reset;
   logic [8*NSRC-1:0]    src_data;
   logic [NSRC-1:0]      src_data_valid;
   logic [NSRC-1:0]      src_frame_valid;
   logic [NSRC-1:0]      src_wait;
   logic [7:0]           tx_data;
   logic                 tx_valid;
   logic                 tx_ready;
   logic [2:0]           grant_id;
   logic                 frame_abort;
   logic [15:0]          frame_count;

   message_arbiter #(.NUM_SRC(NSRC), .TIMEOUT(TMO)) dut (
      .clk             (clk),
      .reset           (reset),
      .src_data        (src_data),
      .src_data_valid  (src_data_valid),
      .src_frame_valid (src_frame_valid),
      .src_wait        (src_wait),
      .tx_data         (tx_data),
      .tx_valid        (tx_valid),
      .tx_ready        (tx_ready),
      .grant_id        (grant_id),
      .frame_abort     (frame_abort),
      .frame_count     (frame_count)
   );

   always #5 clk = ~clk;

   int chk_cnt = 0;
   int pass_cnt = 0;
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   logic [7:0] exp_q[$];
   int         pop_cyc[$];
   bit         arm_lat = 0;
   int         first_tx_cyc = 0;
   int         req_cyc = 0;
   bit         ready_pat[$];

   logic [7:0] sbytes [NSRC][64];
   int         slen   [NSRC][8];
   int         nfr    [NSRC];
   int         sfill  [NSRC];

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] expv);
      chk_cnt++;
      if (got === expv) pass_cnt++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, expv);
   endtask

   // Monitor: every accepted tx byte must be the next expected byte.
   always @(negedge clk) begin
      #4;
      if (!reset && tx_valid && tx_ready) begin
         if (exp_q.size() == 0) begin
            check("tx_extra_byte", 32'(exp_q.size()), 32'd1);
         end else begin
            check("tx_data", 32'(tx_data), 32'(exp_q.pop_front()));
            pop_cyc.push_back(cyc);
            if (arm_lat) begin
               first_tx_cyc = cyc;
               arm_lat = 0;
            end
         end
      end
   end

   task automatic add_frame(input int s, input int len, input logic [31:0] w);
      logic [31:0] wv;
      wv = w;
      for (int k = 0; k < len; k++) begin
         sbytes[s][sfill[s]+k] = (k < 4) ? wv[8*(k%4) +: 8] : 8'($urandom);
      end
      slen[s][nfr[s]] = len;
      nfr[s]++;
      sfill[s] += len;
   endtask

   // Reference: frames are served whole, next source after the last served one.
   task automatic build_expected(output int total);
      int ptr;
      int found;
      int fidx [NSRC];
      int off  [NSRC];
      ptr = 0;
      total = 0;
      for (int s = 0; s < NSRC; s++) begin
         fidx[s] = 0;
         off[s] = 0;
      end
      while (1) begin
         found = -1;
         for (int k = 0; k < NSRC; k++) begin
            if (found < 0 && fidx[(ptr+k)%NSRC] < nfr[(ptr+k)%NSRC]) found = (ptr+k)%NSRC;
         end
         if (found < 0) break;
         for (int b = 0; b < slen[found][fidx[found]]; b++)
            exp_q.push_back(sbytes[found][off[found]+b]);
         off[found] += slen[found][fidx[found]];
         fidx[found]++;
         total++;
         ptr = (found + 1) % NSRC;
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset = 1;
      src_frame_valid = '0;
      src_data_valid = '0;
      src_data = '0;
      tx_ready = 0;
      exp_q.delete();
      pop_cyc.delete();
      arm_lat = 0;
      for (int s = 0; s < NSRC; s++) begin
         nfr[s] = 0;
         sfill[s] = 0;
      end
      @(negedge clk);
      reset = 0;
   endtask

   // Source drivers. mode 0: tx_ready=1; 1: ready_pat then 1; 2: random ready and bubbles.
   task automatic run_sources(input int mode, input int max_cyc);
      int fidx [NSRC];
      int pos  [NSRC];
      int off  [NSRC];
      bit gap  [NSRC];
      bit done [NSRC];
      bit dv   [NSRC];
      int stall_run;
      bit all_done;
      bit force_go;
      bit stall;
      logic [NSRC-1:0] sw;
      stall_run = 0;
      for (int s = 0; s < NSRC; s++) begin
         fidx[s] = 0; pos[s] = 0; off[s] = 0; gap[s] = 0; dv[s] = 0;
         done[s] = (nfr[s] == 0);
      end
      for (int n = 0; n < max_cyc; n++) begin
         all_done = 1;
         for (int s = 0; s < NSRC; s++) if (!done[s]) all_done = 0;
         if (all_done) break;
         @(negedge clk);
         if (n == 0) req_cyc = cyc;
         force_go = (stall_run >= 3);
         if (mode == 1) tx_ready = (ready_pat.size() > 0) ? ready_pat.pop_front() : 1'b1;
         else if (mode == 2 && !force_go) tx_ready = ($urandom_range(3) != 0);
         else tx_ready = 1;
         stall = !tx_ready;
         for (int s = 0; s < NSRC; s++) begin
            if (done[s] || gap[s]) begin
               dv[s] = 0;
               src_frame_valid[s] = 0;
               src_data_valid[s] = 0;
            end else begin
               dv[s] = !(mode == 2 && !force_go && $urandom_range(4) == 0);
               if (!dv[s]) stall = 1;
               src_frame_valid[s] = 1;
               src_data_valid[s] = dv[s];
               src_data[8*s +: 8] = sbytes[s][off[s]+pos[s]];
            end
         end
         stall_run = stall ? stall_run + 1 : 0;
         #4;
         sw = src_wait;
         check("src_wait_at_most_one_low", 32'($countones(~sw) <= 1), 32'd1);
         if (tx_valid && !tx_ready) check("src_wait_under_backpressure", 32'(sw), 32'hF);
         for (int s = 0; s < NSRC; s++) begin
            if (gap[s]) begin
               gap[s] = 0;
               off[s] += slen[s][fidx[s]];
               fidx[s]++;
               pos[s] = 0;
               if (fidx[s] >= nfr[s]) done[s] = 1;
            end else if (!done[s] && dv[s] && !sw[s]) begin
               pos[s]++;
               if (pos[s] == slen[s][fidx[s]]) gap[s] = 1;
            end
         end
      end
      all_done = 1;
      for (int s = 0; s < NSRC; s++) if (!done[s]) all_done = 0;
      check("sources_finished_in_budget", 32'(all_done), 32'd1);
      @(negedge clk);
      src_frame_valid = '0;
      src_data_valid = '0;
      tx_ready = 1;
      repeat (4) @(negedge clk);
   endtask

   initial begin
      int tot;
      int abort_at;
      int abort_n;
      bit taken;
      reset = 1;
      src_data = '0;
      src_data_valid = '0;
      src_frame_valid = '0;
      tx_ready = 0;
      for (int s = 0; s < NSRC; s++) begin
         nfr[s] = 0;
         sfill[s] = 0;
      end

      // Reset values.
      @(negedge clk); #4;
      check("rst_tx_valid", 32'(tx_valid), 32'd0);
      check("rst_tx_data", 32'(tx_data), 32'd0);
      check("rst_src_wait", 32'(src_wait), 32'hF);
      check("rst_frame_abort", 32'(frame_abort), 32'd0);
      check("rst_frame_count", 32'(frame_count), 32'd0);
      check("rst_grant_id", 32'(grant_id), 32'd0);

      // Single source 0: 00 5A 00.
      do_reset();
      add_frame(0, 3, 32'h0000_5A00);
      build_expected(tot);
      arm_lat = 1;
      run_sources(0, 100);
      check("single_latency", 32'(first_tx_cyc - req_cyc), 32'd2);
      check("single_pop_count", 32'(pop_cyc.size()), 32'd3);
      if (pop_cyc.size() == 3) check("single_back_to_back", 32'(pop_cyc[2] - pop_cyc[0]), 32'd2);
      check("single_frame_count", 32'(frame_count), 32'(tot));
      check("single_grant_id", 32'(grant_id), 32'd0);
      check("single_sb_empty", 32'(exp_q.size()), 32'd0);

      // Contention between sources 1 and 3.
      do_reset();
      add_frame(1, 3, 32'h0013_1211);
      add_frame(3, 3, 32'h0033_3231);
      build_expected(tot);
      run_sources(0, 100);
      check("contend_frame_count", 32'(frame_count), 32'd2);
      check("contend_grant_id", 32'(grant_id), 32'd3);
      check("contend_sb_empty", 32'(exp_q.size()), 32'd0);

      // Backpressure on a 4-byte frame.
      do_reset();
      add_frame(2, 4, 32'hD4C3_B2A1);
      build_expected(tot);
      ready_pat = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
      run_sources(1, 100);
      check("bp_frame_count", 32'(frame_count), 32'd1);
      check("bp_sb_empty", 32'(exp_q.size()), 32'd0);

      // Fairness: every source, two 1-byte frames each.
      do_reset();
      for (int f = 0; f < 2; f++)
         for (int s = 0; s < NSRC; s++) add_frame(s, 1, 32'((s << 4) | f));
      build_expected(tot);
      run_sources(0, 200);
      check("fair_frame_count", 32'(frame_count), 32'd8);
      check("fair_sb_empty", 32'(exp_q.size()), 32'd0);

      // Randomized rounds.
      for (int r = 0; r < 3; r++) begin
         do_reset();
         for (int s = 0; s < NSRC; s++) begin
            int nf;
            nf = (s == r) ? 1 + $urandom_range(2) : $urandom_range(3);
            for (int f = 0; f < nf; f++) add_frame(s, 1 + $urandom_range(5), $urandom);
         end
         build_expected(tot);
         run_sources(2, 3000);
         check("rand_frame_count", 32'(frame_count), 32'(tot));
         check("rand_sb_empty", 32'(exp_q.size()), 32'd0);
      end

      // Watchdog: source 2 sends one byte then stalls.
      do_reset();
      @(negedge clk);
      tx_ready = 1;
      src_frame_valid = 4'b0100;
      src_data_valid = 4'b0100;
      src_data[23:16] = 8'hC3;
      exp_q.push_back(8'hC3);
      taken = 0;
      for (int k = 0; k < 8 && !taken; k++) begin
         #4;
         if (!src_wait[2]) taken = 1;
         else @(negedge clk);
      end
      check("wd_first_take", 32'(taken), 32'd1);
      @(negedge clk);
      src_data_valid = '0;
      abort_at = 0;
      abort_n = 0;
      for (int k = 1; k <= 24; k++) begin
         #4;
         if (frame_abort) begin
            abort_n++;
            if (abort_at == 0) abort_at = k;
            src_frame_valid = '0;
         end
         @(negedge clk);
      end
      check("wd_abort_sample", 32'(abort_at), 32'd17);
      check("wd_abort_pulses", 32'(abort_n), 32'd1);
      check("wd_frame_count", 32'(frame_count), 32'd0);
      check("wd_grant_id", 32'(grant_id), 32'd2);
      check("wd_sb_empty", 32'(exp_q.size()), 32'd0);

      // Asynchronous reset during byte 2 of a frame.
      do_reset();
      add_frame(1, 1, 32'h0000_0077);
      build_expected(tot);
      run_sources(0, 100);
      check("ar_pre_count", 32'(frame_count), 32'd1);
      @(negedge clk);
      tx_ready = 1;
      src_frame_valid = 4'b0001;
      src_data_valid = 4'b0001;
      src_data[7:0] = 8'h11;
      taken = 0;
      for (int k = 0; k < 8 && !taken; k++) begin
         #4;
         if (!src_wait[0]) taken = 1;
         else @(negedge clk);
      end
      check("ar_first_take", 32'(taken), 32'd1);
      @(negedge clk);
      src_data[7:0] = 8'h22;
      #2;
      reset = 1;
      #1;
      check("ar_tx_valid", 32'(tx_valid), 32'd0);
      check("ar_src_wait", 32'(src_wait), 32'hF);
      check("ar_frame_count", 32'(frame_count), 32'd0);
      check("ar_tx_data", 32'(tx_data), 32'd0);
      exp_q.delete();
      src_frame_valid = '0;
      src_data_valid = '0;
      @(negedge clk);
      reset = 0;
      repeat (3) @(negedge clk);

      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL global_timeout: simulation did not reach its end, passed %0d of %0d", pass_cnt, chk_cnt);
      $fatal(1, "timeout");
   end

endmodule
